// File: rtl/fft_frame_loader.sv
// Serial sample loader for the FFT controller.
// Samples are written into ping-pong banks at bit-reversed addresses, giving DIT input order.
// A full bank is launched to the FFT when it is idle. The launched bank is held until fft_done.
module fft_frame_loader #(
  parameter int unsigned BITS  = 16,
  parameter int unsigned N     = 64,
  parameter int unsigned LOG2N = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BITS-1:0]   in_data,
  output logic              in_ready,
  input  logic              fft_done,
  output logic              ready_inputs,
  output logic [N*BITS-1:0] frame_out,
  output logic              frame_bank,
  output logic              done_err
);

  logic [BITS-1:0]  bank_q [2][N];
  logic [BITS-1:0]  bank_d [2][N];
  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d;
  logic             lb_q, lb_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             fft_busy_q, fft_busy_d;
  logic             out_bank_q, out_bank_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             accept;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // The write bank stays blocked while it still holds an unconsumed frame.
  assign in_ready     = ~full_q[wb_q];
  assign accept       = in_valid & in_ready;
  assign ready_inputs = ready_q;
  assign frame_bank   = out_bank_q;
  assign done_err     = err_q;

  // Present the launched bank as a flat word vector.
  always_comb begin
    frame_out = '0;
    for (int i = 0; i < N; i++) begin
      frame_out[i*BITS +: BITS] = bank_q[out_bank_q][i];
    end
  end

  // Next state: sample write, launch toward the FFT, and release on fft_done.
  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wb_d       = wb_q;
    lb_d       = lb_q;
    wr_cnt_d   = wr_cnt_q;
    fft_busy_d = fft_busy_q;
    out_bank_d = out_bank_q;
    ready_d    = 1'b0;
    err_d      = err_q;

    if (accept) begin
      bank_d[wb_q][bitrev(wr_cnt_q)] = in_data;
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == LOG2N'(N - 1)) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end

    // Launch only sees banks that were full before this edge.
    if (!fft_busy_q && full_q[lb_q]) begin
      ready_d    = 1'b1;
      out_bank_d = lb_q;
      fft_busy_d = 1'b1;
      lb_d       = ~lb_q;
    end

    // The out bank is never the write bank while busy, so this clear cannot collide
    // with a same-edge fill of the other bank.
    if (fft_done) begin
      if (fft_busy_q) begin
        full_d[out_bank_q] = 1'b0;
        fft_busy_d         = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      full_q     <= '0;
      wb_q       <= 1'b0;
      lb_q       <= 1'b0;
      wr_cnt_q   <= '0;
      fft_busy_q <= 1'b0;
      out_bank_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      full_q     <= full_d;
      wb_q       <= wb_d;
      lb_q       <= lb_d;
      wr_cnt_q   <= wr_cnt_d;
      fft_busy_q <= fft_busy_d;
      out_bank_q <= out_bank_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: frame-level reference model plus directed and random stimulus.
module tb_fft_frame_loader;
  localparam int BITS  = 16;
  localparam int N     = 64;
  localparam int LOG2N = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [BITS-1:0]   in_data = '0;
  logic              fft_done = 1'b0;
  logic              in_ready;
  logic              ready_inputs;
  logic [N*BITS-1:0] frame_out;
  logic              frame_bank;
  logic              done_err;

  fft_frame_loader #(.BITS(BITS), .N(N), .LOG2N(LOG2N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fft_done    (fft_done),
    .ready_inputs(ready_inputs),
    .frame_out   (frame_out),
    .frame_bank  (frame_bank),
    .done_err    (done_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  // Model: partial frame as a queue, completed frames waiting to launch, one launched frame.
  logic [BITS-1:0]   part_q[$];
  logic [N*BITS-1:0] pend_q[$];
  bit                pend_bank_q[$];
  logic [N*BITS-1:0] m_frame;
  bit m_init = 0, m_busy = 0, m_ready = 0, m_err = 0, m_bank = 0, m_zero = 1;
  int unsigned m_frames = 0;

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (((v >> b) & 1) != 0) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic int held();
    return pend_q.size() + (m_busy ? 1 : 0);
  endfunction

  function automatic logic [BITS-1:0] word(input int i);
    return frame_out[i*BITS +: BITS];
  endfunction

  function automatic logic [BITS-1:0] w16(input int v);
    logic [BITS-1:0] r;
    r = BITS'(v);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input logic [N*BITS-1:0] exp);
    checks++;
    if (frame_out !== exp) begin
      failures++;
      for (int i = 0; i < N; i++) begin
        if (frame_out[i*BITS +: BITS] !== exp[i*BITS +: BITS]) begin
          $display("FAIL %s: word %0d got %0h expected %0h at %0t", name, i,
                   frame_out[i*BITS +: BITS], exp[i*BITS +: BITS], $time);
          break;
        end
      end
    end
  endtask

  // Reference model advances on each rising edge from the inputs held across that edge.
  always @(posedge clk) begin
    bit acc, launch, rel;
    logic [N*BITS-1:0] f;
    if (rst) begin
      part_q.delete(); pend_q.delete(); pend_bank_q.delete();
      m_busy = 0; m_ready = 0; m_err = 0; m_bank = 0; m_zero = 1; m_frames = 0; m_init = 1;
    end else begin
      acc    = in_valid && (held() < 2);
      launch = !m_busy && (pend_q.size() > 0);
      rel    = fft_done && m_busy;
      if (fft_done && !m_busy) m_err = 1;
      m_ready = launch;
      if (launch) begin
        m_frame = pend_q.pop_front();
        m_bank  = pend_bank_q.pop_front();
        m_busy  = 1;
      end else if (rel) begin
        m_busy = 0;
      end
      if (acc) begin
        m_zero = 0;
        part_q.push_back(in_data);
        if (part_q.size() == N) begin
          for (int i = 0; i < N; i++) f[i*BITS +: BITS] = part_q[brev(i)];
          pend_q.push_back(f);
          pend_bank_q.push_back(m_frames[0]);
          m_frames++;
          part_q.delete();
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(held() < 2));
      chk("ready_inputs", 32'(ready_inputs), 32'(m_ready));
      chk("done_err", 32'(done_err), 32'(m_err));
      chk("frame_bank", 32'(frame_bank), 32'(m_bank));
      if (m_busy) chk_frame("frame_out_busy", m_frame);
      else if (m_zero) chk_frame("frame_out_reset", '0);
      if (ready_inputs) pulse_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; fft_done = 0;
    step(); step();
    rst = 0;
    pulse_cnt = 0;
  endtask

  task automatic feed(input int n, input int base, input bit neg);
    for (int k = 0; k < n; k++) begin
      in_valid = 1;
      in_data  = neg ? w16(-(base + k)) : w16(base + k);
      step();
    end
    in_valid = 0;
  endtask

  task automatic done_pulse();
    fft_done = 1; step(); fft_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, k;
    bit a;

    // T1 reset
    do_reset();
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_ready_inputs", 32'(ready_inputs), 32'd0);
    chk("t1_done_err", 32'(done_err), 32'd0);
    chk("t1_frame_bank", 32'(frame_bank), 32'd0);
    chk_frame("t1_frame_zero", '0);

    // T2 one ramp frame
    feed(64, 0, 0);
    chk("t2_no_early_pulse", 32'(ready_inputs), 32'd0);
    step();
    chk("t2_pulse", 32'(ready_inputs), 32'd1);
    chk("t2_word1", 32'(word(1)), 32'd32);
    chk("t2_word32", 32'(word(32)), 32'd1);
    chk("t2_word63", 32'(word(63)), 32'd63);
    chk("t2_word6", 32'(word(6)), 32'd24);
    chk("t2_bank", 32'(frame_bank), 32'd0);
    step();
    chk("t2_pulse_one_cycle", 32'(ready_inputs), 32'd0);
    chk("t2_pulse_count", 32'(pulse_cnt), 32'd1);
    done_pulse();

    // T3 two frames with FFT stalled
    do_reset();
    acc = 0; cyc = 0; in_valid = 1;
    while (acc < 128 && cyc < 1000) begin
      in_data = w16(acc);
      a = in_ready;
      step();
      if (a) acc++;
      cyc++;
    end
    in_valid = 0;
    chk("t3_accept_budget", 32'(acc), 32'd128);
    chk("t3_blocked", 32'(in_ready), 32'd0);
    step(); step();
    chk("t3_still_blocked", 32'(in_ready), 32'd0);
    done_pulse();
    chk("t3_resume", 32'(in_ready), 32'd1);
    step();
    chk("t3_pulse", 32'(ready_inputs), 32'd1);
    chk("t3_bank1", 32'(frame_bank), 32'd1);
    chk("t3_word1", 32'(word(1)), 32'd96);
    step();
    done_pulse();

    // T4 alternating valid, negated ramp, garbage data on idle cycles
    do_reset();
    k = 0; cyc = 0;
    while (k < 64 && cyc < 400) begin
      in_valid = (cyc % 2) == 0;
      in_data  = in_valid ? w16(-k) : 16'hdead;
      a = in_valid && in_ready;
      step();
      if (a) k++;
      cyc++;
    end
    in_valid = 0;
    step();
    chk("t4_pulse", 32'(ready_inputs), 32'd1);
    chk("t4_word1", 32'(word(1)), 32'(w16(-32)));
    chk("t4_word6", 32'(word(6)), 32'(w16(-24)));
    step(); step();
    chk("t4_pulse_count", 32'(pulse_cnt), 32'd1);
    done_pulse();

    // T5 spurious fft_done mid-frame
    do_reset();
    feed(5, 0, 0);
    done_pulse();
    chk("t5_err_set", 32'(done_err), 32'd1);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    step(); step(); step();
    chk("t5_err_sticky", 32'(done_err), 32'd1);
    feed(59, 5, 0);
    step();
    chk("t5_pulse_on_time", 32'(ready_inputs), 32'd1);
    chk("t5_word32", 32'(word(32)), 32'd1);
    done_pulse();
    chk("t5_err_still", 32'(done_err), 32'd1);

    // T6 reset mid-frame then a fresh frame
    do_reset();
    feed(10, 500, 0);
    rst = 1; step(); rst = 0;
    pulse_cnt = 0;
    chk("t6_no_pulse", 32'(ready_inputs), 32'd0);
    feed(64, 1000, 0);
    step();
    chk("t6_word0", 32'(word(0)), 32'd1000);
    chk("t6_word1", 32'(word(1)), 32'd1032);
    chk("t6_bank", 32'(frame_bank), 32'd0);
    step(); step();
    chk("t6_pulse_count", 32'(pulse_cnt), 32'd1);
    done_pulse();

    // Random traffic, spurious and real fft_done, occasional reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data  = BITS'($urandom);
      fft_done = $urandom_range(0, 15) == 0;
      rst      = $urandom_range(0, 599) == 0;
      step();
    end
    in_valid = 0; fft_done = 0; rst = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
